// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - Iterative AES inverse cipher, one round per clock
//
// Decrypts one 128-bit block using the encryption key schedule applied in
// reverse order. One inverse round is evaluated per clock; valid/ready
// handshakes on the ciphertext and plaintext sides.
//
// Optional feature: define AES_INV_FLUSH_EN to add the flush input, which
// drops the block in flight and returns the FSM to IDLE.
//
// Ports:
//   clk        in   1            clock, rising edge
//   rst        in   1            synchronous active-high reset
//   flush      in   1            (AES_INV_FLUSH_EN only) abort current block
//   in_valid   in   1            ct and rkey valid
//   in_ready   out  1            high in IDLE only
//   ct         in   128          ciphertext, bits 127:120 = byte 0
//   rkey       in   128*(Nr+1)   expanded schedule; word i at
//                                rkey[128*(Nr+1)-1-32*i -: 32] (word 0 in MSBs)
//   out_valid  out  1            pt holds a completed plaintext
//   out_ready  in   1            downstream accepts pt
//   pt         out  128          plaintext (zero when not DONE)

module aes_inv_cipher_iter #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef AES_INV_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           ct,
    input  logic [128*(Nr+1)-1:0]  rkey,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           pt
);

    localparam int RW = $clog2(Nr);
    localparam int KW = 128 * (Nr + 1);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // GF(2^8) helpers, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map, then invert in GF(2^8)
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [127:0] InvSubBytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Byte 4c+r is row r of column c; row r rotates right by r columns
    function automatic logic [127:0] InvShiftRows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] InvMixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] AddRoundKey(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

    // Round key r is schedule words 4r..4r+3, word 4r in the MSBs
    logic [127:0] rk [Nr+1];
    for (genvar g = 0; g <= Nr; g++) begin : g_rk
        assign rk[g] = rkey[KW-1-128*g -: 128];
    end

    state_t        state_q, state_d;
    logic [127:0]  s_q, s_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic [127:0]  inv_core;
    logic          flush_act;

`ifdef AES_INV_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Shared front half of every inverse round
    assign inv_core = InvSubBytes(InvShiftRows(s_q));

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        pt        = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                // A flush in IDLE also blocks acceptance that cycle
                if (in_valid && !flush_act) begin
                    s_d     = AddRoundKey(ct, rk[Nr]);
                    rnd_d   = RW'(Nr - 1);
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (rnd_q != '0) begin
                    s_d   = InvMixColumns(AddRoundKey(inv_core, rk[rnd_q]));
                    rnd_d = rnd_q - 1'b1;
                end else begin
                    s_d     = AddRoundKey(inv_core, rk[0]);
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                pt        = s_q;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_act && state_q != IDLE) begin
            state_d = IDLE;
            s_d     = '0;
            rnd_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            rnd_q   <= rnd_d;
        end
    end

endmodule
